lsu_mem_adapter: RTL and testbench
==================================

LSU_MEM_ADAPTER -- requirements
Module: lsu_mem_adapter

Interface
REQ-001 SHALL have parameter MEMSIZE, default 'h400, data memory size in bytes (power of two, multiple of 4).
REQ-002 SHALL derive localparam WIDTH = $clog2(MEMSIZE), the memory byte-address width.
REQ-003 clk  input  1  single clock, all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU load/store request present.
REQ-006 req_ready  output  1  adapter accepts request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I size/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, LSB-aligned.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  CPU accepts response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected (misaligned, out of range, illegal funct3).
REQ-015 mem_en  output  1  memory enable to word memory.
REQ-016 mem_wen  output  1  memory write enable.
REQ-017 mem_addr  output  WIDTH  word-aligned byte address {addr[WIDTH-1:2],2'b00}.
REQ-018 mem_wdata  output  32  full word to write.
REQ-019 mem_rdata  input  32  combinational read data, valid the same cycle as mem_en=1, mem_wen=0.

Function
REQ-020 States SHALL be IDLE, ACCESS, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-021 Request SHALL be accepted on req_valid & req_ready; address, data, we and funct3 latched.
REQ-022 Error at accept SHALL be: funct3 in {3,6,7}; store with funct3 in {4,5}; H/HU with addr[0]=1; W with addr[1:0]!=0; addr >= MEMSIZE.
REQ-023 Error: IDLE -> RESP, rsp_err=1, rsp_rdata=0, mem_en never asserted for that request.
REQ-024 Load: IDLE -> ACCESS -> RESP; in ACCESS mem_en=1, mem_wen=0; rsp_valid first high 2 cycles after accept.
REQ-025 Load extraction: byte lane = addr[1:0], halfword lane = addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-026 Store word: IDLE -> WRITE -> RESP; in WRITE mem_en=1, mem_wen=1, mem_wdata=req_wdata; rsp_valid 2 cycles after accept.
REQ-027 Store B/H: IDLE -> ACCESS (read old word, register it) -> WRITE (merged word) -> RESP; rsp_valid 3 cycles after accept.
REQ-028 Merge SHALL replace only bytes selected by mask (B: 1 byte, H: 2 bytes) shifted by addr[1:0]*8; other bytes keep read value.
REQ-029 Memory access SHALL occur exactly once per state; mem_en, mem_wen, mem_addr, mem_wdata = 0 outside ACCESS/WRITE.
REQ-030 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready=1; then -> IDLE next cycle.
REQ-031 Successful store SHALL respond rsp_err=0, rsp_rdata=0.
REQ-032 No new request SHALL be accepted in the cycle of the response handshake; earliest next accept is the following cycle.
REQ-033 Address bits above WIDTH SHALL be checked only for range (REQ-022), never forwarded.

Reset
REQ-034 reset=1 SHALL force next state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, latched request cleared.
REQ-035 mem_en and mem_wen SHALL be 0 in any cycle reset=1, regardless of state; in-flight request discarded, no response produced.
REQ-036 req_ready SHALL be 0 while reset=1.

Verification
REQ-037 SW 0x10 data 0xDEADBEEF, then LW 0x10 -> one write of 0xDEADBEEF at mem_addr 0x10; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-038 Word 0x14 = 0x11223344; SB 0x17 data 0x000000AA -> ACCESS then WRITE 0xAA223344, response 3 cycles after accept; LB 0x17 -> 0xFFFFFFAA; LBU 0x17 -> 0x000000AA.
REQ-039 SH 0x16 data 0x8001 onto 0x11223344 -> 0x80013344; LH 0x16 -> 0xFFFF8001; LHU 0x16 -> 0x00008001.
REQ-040 LH 0x11, LW 0x12, LW 0x400, SB funct3=4 -> each rsp_err=1, rsp_rdata=0, mem_en 0 throughout.
REQ-041 rsp_ready held 0 for 5 cycles after LW -> rsp_valid/rsp_rdata constant, req_ready=0; accept on cycle 6, req_ready=1 the cycle after.
REQ-042 reset asserted during ACCESS of SB 0x13 -> no mem_wen pulse, memory word unchanged, rsp_valid=0 and req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between an RV32I pipeline and a word-wide data memory.
// Requests are checked for legality when accepted. Legal requests are then
// carried out against the memory. Sub-word stores are done as a read of the
// old word, a merge of the new bytes, and a write of the merged word.
// One response is held for each request until the CPU accepts it.
module lsu_mem_adapter #(
  parameter int  MEMSIZE = 'h400,
  localparam int WIDTH   = $clog2(MEMSIZE)
) (
  input  logic             clk,
  input  logic             reset,
  // CPU request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  // CPU response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  // word memory port (combinational read)
  output logic             mem_en,
  output logic             mem_wen,
  output logic [WIDTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  state_t           state_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [31:0]      wdata_reg;
  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [31:0]      wword_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;
  logic [31:0]      rsp_rdata_reg;

  logic             req_err_next;
  logic [31:0]      load_data_next;
  logic [31:0]      merge_word_next;
  logic [3:0]       byte_mask_next;
  logic [31:0]      wdata_shift_next;
  logic [31:0]      rdata_shift_next;
  logic [7:0]       load_byte_next;
  logic [15:0]      load_half_next;
  logic             mem_active_next;

  // Legality of the request currently offered; only meaningful at accept.
  always_comb begin
    req_err_next = 1'b0;
    unique case (req_funct3)
      F3_B, F3_BU: req_err_next = 1'b0;
      F3_H, F3_HU: req_err_next = req_addr[0];
      F3_W:        req_err_next = (req_addr[1:0] != 2'b00);
      default:     req_err_next = 1'b1;
    endcase
    // Unsigned sub-word variants have no meaning for stores.
    if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU)) begin
      req_err_next = 1'b1;
    end
    // The upper address bits are used only here and never reach the memory.
    if (req_addr >= 32'(MEMSIZE)) begin
      req_err_next = 1'b1;
    end
  end

  // Select the addressed lane from the read word and extend it to 32 bits.
  always_comb begin
    rdata_shift_next = mem_rdata >> {addr_reg[1:0], 3'b000};
    load_byte_next   = rdata_shift_next[7:0];
    load_half_next   = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_reg)
      F3_B:    load_data_next = {{24{load_byte_next[7]}}, load_byte_next};
      F3_H:    load_data_next = {{16{load_half_next[15]}}, load_half_next};
      F3_BU:   load_data_next = {24'h000000, load_byte_next};
      F3_HU:   load_data_next = {16'h0000, load_half_next};
      default: load_data_next = mem_rdata;
    endcase
  end

  // Byte-enable mask and the store data moved into the addressed lanes.
  always_comb begin
    byte_mask_next   = (funct3_reg[0] ? 4'b0011 : 4'b0001) << addr_reg[1:0];
    wdata_shift_next = wdata_reg << {addr_reg[1:0], 3'b000};
  end

  // Each byte lane keeps the old memory byte unless the mask selects it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
      assign merge_word_next[8*gi +: 8] = byte_mask_next[gi]
                                        ? wdata_shift_next[8*gi +: 8]
                                        : mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Request/response sequencer: latches the request, walks the memory
  // states, and holds the response until the CPU takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      funct3_reg    <= '0;
      wword_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg   <= req_addr[WIDTH-1:0];
            wdata_reg  <= req_wdata;
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            if (req_err_next) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              state_reg     <= RESP;
            end else if (req_we && req_funct3 == F3_W) begin
              // Full-word store needs no read of the old word.
              wword_reg <= req_wdata;
              state_reg <= WRITE;
            end else begin
              state_reg <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (we_reg) begin
            wword_reg <= merge_word_next;
            state_reg <= WRITE;
          end else begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= load_data_next;
            state_reg     <= RESP;
          end
        end
        WRITE: begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= '0;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Memory port is driven only in ACCESS/WRITE and is forced quiet in reset.
  always_comb begin
    mem_active_next = (state_reg == ACCESS) || (state_reg == WRITE);
    mem_en    = mem_active_next && !reset;
    mem_wen   = (state_reg == WRITE) && !reset;
    mem_addr  = mem_active_next ? {addr_reg[WIDTH-1:2], 2'b00} : '0;
    mem_wdata = (state_reg == WRITE) ? wword_reg : '0;
  end

  assign req_ready = (state_reg == IDLE) && !reset;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a simple word memory attached.
module tb_lsu_mem_adapter;

  localparam int MEMSIZE = 'h400;
  localparam int WIDTH   = $clog2(MEMSIZE);

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr, req_wdata;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [31:0]      rsp_rdata;
  logic             mem_en, mem_wen;
  logic [WIDTH-1:0] mem_addr;
  logic [31:0]      mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  lsu_mem_adapter #(.MEMSIZE(MEMSIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with combinational read; records every write.
  logic [31:0] mem [0:255];
  int          wr_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  assign mem_rdata = mem[mem_addr[WIDTH-1:2]];

  always @(posedge clk) begin
    if (mem_en && mem_wen) begin
      mem[mem_addr[WIDTH-1:2]] <= mem_wdata;
      wr_count   <= wr_count + 1;
      last_waddr <= 32'(mem_addr);
      last_wdata <= mem_wdata;
    end
  end

  // Per-cycle activity counters for the memory port.
  int en_total  = 0;
  int wen_total = 0;
  always @(negedge clk) begin
    en_total  <= en_total + int'(mem_en);
    wen_total <= wen_total + int'(mem_wen);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction: offer, accept, wait for response, optionally
  // stall rsp_ready for 'hold' cycles, then handshake.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input logic [31:0] exp_hold,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int en_cnt, output int wen_cnt);
    int en0, wen0, waits;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) check_val("accept_timeout", 32'(req_ready), 32'd1);
    en0 = en_total; wen0 = wen_total;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) check_val("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_rdata", rsp_rdata, exp_hold);
      check_val("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("post_req_ready", 32'(req_ready), 32'd1);
    check_val("post_rsp_valid", 32'(rsp_valid), 32'd0);
    en_cnt  = en_total - en0;
    wen_cnt = wen_total - wen0;
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d en=%0d wen=%0d",
             we, f3, addr, wdata, rdata, err, lat, en_cnt, wen_cnt);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, en_c, wen_c, wr0;

  // Error vectors: each must be rejected without touching memory.
  logic        err_we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0]  err_f3   [4] = '{3'd1, 3'd2, 3'd2, 3'd4};
  logic [31:0] err_addr [4] = '{32'h11, 32'h12, 32'h400, 32'h10};

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_mem_en", 32'(mem_en), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rel_req_ready", 32'(req_ready), 32'd1);

    // SW then LW of a full word
    wr0 = wr_count;
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("sw_lat", 32'(lat), 32'd2);
    check_val("sw_err", 32'(er), 32'd0);
    check_val("sw_rdata", rd, 32'h0);
    check_val("sw_wen_cycles", 32'(wen_c), 32'd1);
    check_val("sw_writes", 32'(wr_count - wr0), 32'd1);
    check_val("sw_waddr", last_waddr, 32'h10);
    check_val("sw_wdata", last_wdata, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("lw_rdata", rd, 32'hDEADBEEF);
    check_val("lw_err", 32'(er), 32'd0);
    check_val("lw_lat", 32'(lat), 32'd2);
    check_val("lw_en_cycles", 32'(en_c), 32'd1);
    check_val("lw_wen_cycles", 32'(wen_c), 32'd0);

    // Byte store and byte loads in the top lane
    do_req(1'b1, 3'd2, 32'h14, 32'h11223344, 0, 32'h0, rd, er, lat, en_c, wen_c);
    do_req(1'b1, 3'd0, 32'h17, 32'h000000AA, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("sb_lat", 32'(lat), 32'd3);
    check_val("sb_en_cycles", 32'(en_c), 32'd2);
    check_val("sb_wen_cycles", 32'(wen_c), 32'd1);
    check_val("sb_wdata", last_wdata, 32'hAA223344);
    check_val("sb_waddr", last_waddr, 32'h14);
    check_val("sb_err", 32'(er), 32'd0);
    do_req(1'b0, 3'd0, 32'h17, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("lb_17", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h17, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("lbu_17", rd, 32'h000000AA);

    // Halfword store and loads in the upper half, then lower-lane loads
    do_req(1'b1, 3'd2, 32'h14, 32'h11223344, 0, 32'h0, rd, er, lat, en_c, wen_c);
    do_req(1'b1, 3'd1, 32'h16, 32'h00008001, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("sh_lat", 32'(lat), 32'd3);
    check_val("sh_wdata", last_wdata, 32'h80013344);
    do_req(1'b0, 3'd1, 32'h16, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("lh_16", rd, 32'hFFFF8001);
    do_req(1'b0, 3'd5, 32'h16, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("lhu_16", rd, 32'h00008001);
    do_req(1'b0, 3'd0, 32'h14, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("lb_14", rd, 32'h00000044);
    do_req(1'b0, 3'd1, 32'h14, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("lh_14", rd, 32'h00003344);

    // Rejected requests
    for (int k = 0; k < 4; k++) begin
      do_req(err_we[k], err_f3[k], err_addr[k], 32'hFFFFFFFF, 0, 32'h0,
             rd, er, lat, en_c, wen_c);
      check_val($sformatf("err%0d_err", k), 32'(er), 32'd1);
      check_val($sformatf("err%0d_rdata", k), rd, 32'h0);
      check_val($sformatf("err%0d_lat", k), 32'(lat), 32'd1);
      check_val($sformatf("err%0d_en", k), 32'(en_c), 32'd0);
    end

    // Response back-pressure
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, 32'hDEADBEEF, rd, er, lat, en_c, wen_c);
    check_val("bp_rdata", rd, 32'hDEADBEEF);

    // Reset in the middle of a sub-word store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h13; req_wdata = 32'h00000055;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("rst_sb_access_en", 32'(mem_en), 32'd1);
    check_val("rst_sb_access_wen", 32'(mem_wen), 32'd0);
    reset = 1'b1;
    #1;
    check_val("rst_sb_en_forced", 32'(mem_en), 32'd0);
    check_val("rst_sb_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_val("rst_sb_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_sb_req_ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sb_no_write", 32'(wr_count - wr0), 32'd0);
    check_val("rst_sb_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'h0, rd, er, lat, en_c, wen_c);
    check_val("rst_sb_word_kept", rd, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
